instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the IF/ID pipeline register: owns the fetch PC and issues requests on the instruction-memory bus.

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions for the front end: word width, the canonical
// no-op encoding and the {instruction, pc} record carried through fetch.
package core_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] instr;
    logic [WORD_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: small synchronous FIFO of fetch entries with flush.
// Head is presented combinationally from the registered storage.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    empty   = (count == '0);
    full    = (count == (PW+1)'(DEPTH));
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // Storage, pointers and occupancy; flush discards contents and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues instruction-memory requests under a
// credit limit, tags each request with its PC, discards responses made stale
// by a redirect, and presents the prefetch-queue head to IF/ID.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned           FIFO_DEPTH = 2,
  parameter int unsigned           MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_ctrl,
  input  logic                  clear_ctrl,
  input  logic                  branch_taken_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  output logic                  imem_req_o,
  output logic [WORD_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [WORD_WIDTH-1:0] imem_rdata_i,
  output logic [WORD_WIDTH-1:0] instruction_o,
  output logic [WORD_WIDTH-1:0] program_count_o,
  output logic                  no_op_flag_o
);

  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [WORD_WIDTH-1:0] fetch_pc;
  logic [OW-1:0]         outst;
  logic [OW-1:0]         drop;
  logic [WORD_WIDTH-1:0] tag_pc [MAX_OUTST];
  logic [TW-1:0]         tag_wr;
  logic [TW-1:0]         tag_rd;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  fetch_entry_t          fifo_head;
  fetch_entry_t          push_entry;

  int unsigned           occupancy;
  logic                  issue;
  logic                  fire;
  logic                  resp;
  logic                  resp_drop;

  // Issue/response decode. The entry leaving the queue this cycle is credited
  // back immediately so a 1-cycle memory sustains one instruction per cycle.
  always_comb begin
    fifo_pop   = !stall_ctrl && !branch_taken_i && !fifo_empty;
    occupancy  = 32'(fifo_count) + 32'(outst) - 32'(fifo_pop);
    issue      = rst_n && !branch_taken_i && !(fifo_full && !fifo_pop)
                 && (occupancy < FIFO_DEPTH) && (32'(outst) < MAX_OUTST);
    fire       = issue && imem_gnt_i;
    resp       = imem_rvalid_i && (outst != '0);
    resp_drop  = resp && (drop != '0);
    fifo_flush = branch_taken_i || clear_ctrl;
    fifo_push  = resp && !resp_drop && !branch_taken_i;
    push_entry.instr = imem_rdata_i;
    push_entry.pc    = tag_pc[tag_rd];
  end

  // Bus request and IF/ID-facing outputs, all from registered state plus controls.
  always_comb begin
    imem_req_o      = issue;
    imem_addr_o     = fetch_pc;
    no_op_flag_o    = fifo_empty;
    instruction_o   = fifo_empty ? NOP_INSTR : fifo_head.instr;
    program_count_o = fifo_head.pc;
  end

  // Fetch PC, outstanding-request count and stale-response drop count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= BOOT_ADDR;
      outst    <= '0;
      drop     <= '0;
    end else begin
      if (branch_taken_i) begin
        fetch_pc <= branch_target_i & ~32'h3;
      end else if (fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      case ({fire, resp})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
      // Everything still in flight is stale; a response landing now is already accounted for.
      if (branch_taken_i) begin
        drop <= outst - OW'(resp);
      end else if (resp_drop) begin
        drop <= drop - OW'(1);
      end
    end
  end

  // In-order PC tags for requests in flight; one tag retires per accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr <= '0;
      tag_rd <= '0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) begin
        tag_pc[i] <= '0;
      end
    end else begin
      if (fire) begin
        tag_pc[tag_wr] <= fetch_pc;
        tag_wr <= (tag_wr == TW'(MAX_OUTST - 1)) ? '0 : tag_wr + TW'(1);
      end
      if (resp) begin
        tag_rd <= (tag_rd == TW'(MAX_OUTST - 1)) ? '0 : tag_rd + TW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios driven against a transaction
// model (pending-request list with stale marks, delivered-instruction queue).
module tb_instr_fetch_unit;
  import core_pkg::*;

  typedef struct {
    logic [31:0] pc;
    bit          dead;
    int unsigned due;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_ctrl = 1'b0;
  logic        clear_ctrl = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instruction_o;
  logic [31:0] program_count_o;
  logic        no_op_flag_o;

  instr_fetch_unit #(
    .BOOT_ADDR  (32'h0000_0000),
    .FIFO_DEPTH (2),
    .MAX_OUTST  (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_ctrl      (stall_ctrl),
    .clear_ctrl      (clear_ctrl),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instruction_o   (instruction_o),
    .program_count_o (program_count_o),
    .no_op_flag_o    (no_op_flag_o)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned gdly = 0;
  int unsigned gwait = 0;
  bit          stray = 1'b0;
  logic        rst_pend = 1'b0;
  logic [31:0] exp_pc = '0;
  req_t        pend[$];
  ent_t        mq[$];
  logic [31:0] took[$];
  int unsigned took_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_took(input string name, input int idx, input logic [31:0] v);
    if (idx < took.size()) begin
      chk(name, took[idx], v);
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL %s: only %0d instructions delivered, wanted %h at #%0d", name, took.size(), v, idx);
    end
  endtask

  // Memory side: grant after gdly waiting cycles, answer each request lat cycles after its grant.
  task automatic drive_bus();
    if (!rst_n) begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end else begin
      imem_gnt_i = (gwait >= gdly);
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = pend[0].pc ^ 32'h0000_A5A5;
      end else begin
        imem_rvalid_i = stray;
        imem_rdata_i  = $urandom;
      end
    end
  endtask

  // Compare DUT outputs with the model, then advance the model across the coming edge.
  task automatic monitor();
    bit   pop_now;
    bit   exp_req;
    bit   fire;
    bit   resp;
    int   occ;
    req_t r;
    if (!rst_n) begin
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_noop", 32'(no_op_flag_o), 32'd1);
      chk("rst_instr", instruction_o, NOP_INSTR);
      chk("rst_pc", program_count_o, 32'd0);
      pend.delete();
      mq.delete();
      exp_pc = 32'h0000_0000;
      gwait  = 0;
      cyc++;
      return;
    end
    pop_now = !stall_ctrl && !branch_taken_i && mq.size() != 0;
    occ     = mq.size() + pend.size() - int'(pop_now);
    exp_req = (occ < 2) && (pend.size() < 2) && !branch_taken_i;
    chk("req", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) chk("addr", imem_addr_o, exp_pc);
    if (mq.size() == 0) begin
      chk("noop", 32'(no_op_flag_o), 32'd1);
      chk("nop_instr", instruction_o, NOP_INSTR);
    end else begin
      chk("noop", 32'(no_op_flag_o), 32'd0);
      chk("instr", instruction_o, mq[0].instr);
      chk("pc", program_count_o, mq[0].pc);
    end
    if (pop_now && !clear_ctrl) begin
      took.push_back(mq[0].pc);
      took_cyc.push_back(cyc);
    end
    fire = imem_req_o && imem_gnt_i;
    resp = imem_rvalid_i && pend.size() != 0;
    if (resp) r = pend.pop_front();
    if (branch_taken_i || clear_ctrl) begin
      mq.delete();
    end else begin
      if (pop_now) void'(mq.pop_front());
      if (resp && !r.dead) mq.push_back('{instr: r.pc ^ 32'h0000_A5A5, pc: r.pc});
    end
    if (branch_taken_i) begin
      foreach (pend[i]) pend[i].dead = 1'b1;
      exp_pc = branch_target_i & ~32'h3;
    end
    if (fire) begin
      pend.push_back('{pc: imem_addr_o, dead: 1'b0, due: cyc + lat});
      exp_pc = exp_pc + 32'd4;
    end
    chk("max_outst", 32'(pend.size() <= 2), 32'd1);
    if (fire || !imem_req_o) gwait = 0;
    else gwait++;
    cyc++;
  endtask

  task automatic cycle(input bit st, input bit cl, input bit br, input logic [31:0] tg);
    @(posedge clk);
    #1;
    rst_n           = rst_pend;
    stall_ctrl      = st;
    clear_ctrl      = cl;
    branch_taken_i  = br;
    branch_target_i = tg;
    drive_bus();
    @(negedge clk);
    monitor();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  int unsigned rel;
  int          n0;
  int          k;

  initial begin
    // Reset held for five cycles.
    rst_pend = 1'b0;
    run(5);

    // Release; straight-line fetch, then stall four cycles while pc 8 is presented.
    rst_pend = 1'b1;
    rel = cyc;
    run(4);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      if (i == 2) chk("stall_req_low", 32'(imem_req_o), 32'd0);
    end
    run(6);
    if (took_cyc.size() >= 5) begin
      chk("first_valid_cycle", took_cyc[0] - rel, 32'd2);
      chk("pc8_taken_cycle", took_cyc[2] - rel, 32'd8);
      chk("pc10_taken_cycle", took_cyc[4] - rel, 32'd10);
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL straight_line: only %0d instructions delivered", took.size());
    end
    expect_took("seq0", 0, 32'h0);
    expect_took("seq1", 1, 32'h4);
    expect_took("seq2", 2, 32'h8);
    expect_took("seq3", 3, 32'hC);
    expect_took("seq4", 4, 32'h10);

    // clear_ctrl alone.
    cycle(1'b0, 1'b1, 1'b0, '0);
    run(5);

    // Redirect with two requests in flight.
    lat = 3;
    k = 0;
    while (pend.size() < 2 && k < 20) begin
      run(1);
      k++;
    end
    chk("two_in_flight", 32'(pend.size()), 32'd2);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    n0 = took.size();
    k = 0;
    while (took.size() < n0 + 2 && k < 30) begin
      run(1);
      k++;
    end
    expect_took("redir0", n0, 32'h100);
    expect_took("redir1", n0 + 1, 32'h104);

    // Redirect near the top of memory; low target bits ignored, PC wraps.
    lat = 1;
    run(3);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB);
    n0 = took.size();
    run(8);
    expect_took("wrap0", n0, 32'hFFFF_FFF8);
    expect_took("wrap1", n0 + 1, 32'hFFFF_FFFC);
    expect_took("wrap2", n0 + 2, 32'h0000_0000);

    // Stall, flush and redirect together: redirect wins.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    n0 = took.size();
    run(6);
    expect_took("stall_redir", n0, 32'h40);

    // Slow grant and two-cycle response latency.
    gdly = 3;
    lat  = 2;
    run(30);
    gdly = 0;

    // Asynchronous reset mid-burst.
    k = 0;
    while (pend.size() < 2 && k < 20) begin
      run(1);
      k++;
    end
    @(posedge clk);
    #3;
    rst_pend = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("async_req", 32'(imem_req_o), 32'd0);
    chk("async_noop", 32'(no_op_flag_o), 32'd1);
    chk("async_instr", instruction_o, NOP_INSTR);
    chk("async_pc", program_count_o, 32'd0);
    @(negedge clk);
    monitor();
    lat = 1;
    run(3);
    rst_pend = 1'b1;
    stray    = 1'b1;
    n0 = took.size();
    run(1);
    stray = 1'b0;
    run(6);
    expect_took("boot_after_reset", n0, 32'h0);
    expect_took("boot_after_reset1", n0 + 1, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
